// File: rtl/div_iter_param_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_iter_param_pkg
// Brief  : Shared types, opcode constants and decode for the iterative divider.
// Rev    : 1.0
// ============================================================================
package div_iter_param_pkg;

  // funct3 encodings of the M-extension divide group
  localparam logic [2:0] c_op_div  = 3'b100;
  localparam logic [2:0] c_op_divu = 3'b101;
  localparam logic [2:0] c_op_rem  = 3'b110;
  localparam logic [2:0] c_op_remu = 3'b111;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_PREP = 5'b00010,
    S_ITER = 5'b00100,
    S_FIX  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } opdec_t;

  // Anything outside the four divide opcodes falls through as unsigned quotient.
  function automatic opdec_t decode_op(input logic [2:0] op);
    opdec_t d;
    d.is_signed = (op == c_op_div) || (op == c_op_rem);
    d.is_rem    = (op == c_op_rem) || (op == c_op_remu);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_lzc.sv
`default_nettype none
// ============================================================================
// Module : div_lzc
// Brief  : Leading-zero counter; an all-zero input reports WIDTH.
// Rev    : 1.0
// ============================================================================
module div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       i_data,
  output logic [$clog2(WIDTH):0] o_lzc
);

  localparam int LW = $clog2(WIDTH) + 1;

  // Scanning upward lets the highest set bit overwrite all lower ones.
  always_comb begin
    o_lzc = LW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_lzc = LW'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_iter_param.sv
`default_nettype none
// ============================================================================
// Module : div_iter_param
// Brief  : Multi-cycle restoring divider, 1 or 2 quotient bits per cycle, with
//          leading-zero skip, last-result reuse, flush and tag passthrough.
// Rev    : 1.0
// ============================================================================
module div_iter_param
  import div_iter_param_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BPC      = 1,
  parameter int TAG_W    = 5,
  parameter int REUSE_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  state_t             r_state;
  opdec_t             r_dec;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [TAG_W-1:0]   r_tag;
  logic               r_sa, r_sb, r_dz;
  logic [WIDTH-1:0]   r_ua, r_ub, r_rem, r_quo;
  logic [IW-1:0]      r_idx;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [TAG_W-1:0]   r_tag_o;

  logic               r_c_vld, r_c_sa, r_c_sb, r_c_signed;
  logic [WIDTH-1:0]   r_c_ua, r_c_ub, r_c_q, r_c_r;

  logic               w_sa, w_sb, w_dz, w_hit, w_zero;
  logic [WIDTH-1:0]   w_ua, w_ub;
  logic [LW-1:0]      w_lzc, w_bits, w_ngrp;
  logic [IW-1:0]      w_start;
  logic [BPC-1:0]     w_digit, w_iter_q;
  logic [WIDTH+BPC-1:0] w_trial;
  logic [WIDTH-1:0]   w_iter_rem, w_q_fix, w_r_fix;

  assign in_ready  = (r_state == S_IDLE);
  assign busy_o    = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result_o  = r_result;
  assign tag_o     = r_tag_o;

  assign w_sa = r_dec.is_signed & r_a[WIDTH-1];
  assign w_sb = r_dec.is_signed & r_b[WIDTH-1];
  assign w_ua = w_sa ? -r_a : r_a;
  assign w_ub = w_sb ? -r_b : r_b;
  assign w_dz = (r_b == '0);

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .i_data (w_ua),
    .o_lzc  (w_lzc)
  );

  // First digit group is aligned so the final group always ends at bit 0.
  assign w_bits  = LW'(WIDTH) - w_lzc;
  assign w_ngrp  = (w_bits + LW'(BPC - 1)) / LW'(BPC);
  assign w_start = IW'((w_ngrp * LW'(BPC)) - LW'(1));
  assign w_zero  = (w_ngrp == '0);

  assign w_hit = (REUSE_EN != 0) && r_c_vld && (r_c_ua == w_ua) && (r_c_ub == w_ub) &&
                 (r_c_sa == w_sa) && (r_c_sb == w_sb) && (r_c_signed == r_dec.is_signed);

  assign w_digit = r_ua[r_idx -: BPC];
  assign w_trial = {r_rem, w_digit};

  generate
    if (BPC == 2) begin : g_r4
      logic [WIDTH+1:0] w_d1, w_d2, w_d3;
      assign w_d1 = {2'b00, r_ub};
      assign w_d2 = {1'b0, r_ub, 1'b0};
      assign w_d3 = w_d1 + w_d2;
      always_comb begin
        w_iter_q   = 2'd0;
        w_iter_rem = WIDTH'(w_trial);
        if (w_trial >= w_d3) begin
          w_iter_q   = 2'd3;
          w_iter_rem = WIDTH'(w_trial - w_d3);
        end else if (w_trial >= w_d2) begin
          w_iter_q   = 2'd2;
          w_iter_rem = WIDTH'(w_trial - w_d2);
        end else if (w_trial >= w_d1) begin
          w_iter_q   = 2'd1;
          w_iter_rem = WIDTH'(w_trial - w_d1);
        end
      end
    end else begin : g_r2
      logic [WIDTH:0] w_d1;
      logic           w_ge;
      assign w_d1       = {1'b0, r_ub};
      assign w_ge       = (w_trial >= w_d1);
      assign w_iter_q   = w_ge;
      assign w_iter_rem = w_ge ? WIDTH'(w_trial - w_d1) : WIDTH'(w_trial);
    end
  endgenerate

  // Divide-by-zero bypasses sign fixing; MIN/-1 falls out of plain magnitude math.
  assign w_q_fix = r_dz ? '1  : ((r_sa ^ r_sb) ? -r_quo : r_quo);
  assign w_r_fix = r_dz ? r_a : (r_sa ? -r_rem : r_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dec       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_dz        <= 1'b0;
      r_ua        <= '0;
      r_ub        <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag_o     <= '0;
      r_c_vld     <= 1'b0;
      r_c_sa      <= 1'b0;
      r_c_sb      <= 1'b0;
      r_c_signed  <= 1'b0;
      r_c_ua      <= '0;
      r_c_ub      <= '0;
      r_c_q       <= '0;
      r_c_r       <= '0;
    end else if (flush_i) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dec   <= decode_op(op_i);
            r_a     <= dividend_i;
            r_b     <= divisor_i;
            r_tag   <= tag_i;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sa  <= w_sa;
          r_sb  <= w_sb;
          r_ua  <= w_ua;
          r_ub  <= w_ub;
          r_dz  <= w_dz;
          r_rem <= '0;
          r_quo <= '0;
          r_idx <= w_start;
          if (w_dz) begin
            r_state <= S_FIX;
          end else if (w_hit) begin
            r_result    <= r_dec.is_rem ? r_c_r : r_c_q;
            r_tag_o     <= r_tag;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_zero) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_rem <= w_iter_rem;
          r_quo <= {r_quo[WIDTH-1-BPC:0], w_iter_q};
          if (r_idx == IW'(BPC - 1)) r_state <= S_FIX;
          else                       r_idx   <= r_idx - IW'(BPC);
        end
        S_FIX: begin
          r_result    <= r_dec.is_rem ? w_r_fix : w_q_fix;
          r_tag_o     <= r_tag;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
          if ((REUSE_EN != 0) && !r_dz) begin
            r_c_vld    <= 1'b1;
            r_c_ua     <= r_ua;
            r_c_ub     <= r_ub;
            r_c_sa     <= r_sa;
            r_c_sb     <= r_sb;
            r_c_signed <= r_dec.is_signed;
            r_c_q      <= w_q_fix;
            r_c_r      <= w_r_fix;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`default_nettype none
// ============================================================================
// Module : tb_div_iter_param
// Brief  : Directed vectors on a 32-bit radix-2 divider plus a modelled sweep
//          of a 16-bit radix-4 divider.
// Rev    : 1.0
// ============================================================================
module tb_div_iter_param;

  logic        clk = 1'b0;
  logic        rst_n, flush, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag;
  logic        iv1, ir1, ov1, busy1;
  logic [31:0] res1;
  logic [4:0]  tg1;
  logic        iv2, ir2, ov2, busy2;
  logic [15:0] res2;
  logic [4:0]  tg2;

  always #5 clk = ~clk;

  div_iter_param #(.WIDTH(32), .BPC(1), .TAG_W(5), .REUSE_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op_i(op),
    .dividend_i(a), .divisor_i(b), .tag_i(tag), .flush_i(flush),
    .out_valid(ov1), .out_ready(out_ready), .result_o(res1), .tag_o(tg1), .busy_o(busy1)
  );

  div_iter_param #(.WIDTH(16), .BPC(2), .TAG_W(5), .REUSE_EN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op_i(op),
    .dividend_i(a[15:0]), .divisor_i(b[15:0]), .tag_i(tag), .flush_i(flush),
    .out_valid(ov2), .out_ready(out_ready), .result_o(res2), .tag_o(tg2), .busy_o(busy2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Issue one request to dut1 (sel=0) or dut2 (sel=1); latency counts the accept cycle as 1.
  task automatic issue(input bit sel, input logic [2:0] t_op, input logic [31:0] t_a,
                       input logic [31:0] t_b, input logic [4:0] t_tag, input int flush_after,
                       input int hold, output logic [31:0] t_res, output logic [4:0] t_tg,
                       output int t_lat, output bit t_got);
    op = t_op; a = t_a; b = t_b; tag = t_tag;
    if (sel) iv2 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
    t_lat = 1; t_res = '0; t_tg = '0; t_got = 1'b0;
    if (flush_after >= 0) begin
      repeat (flush_after) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      return;
    end
    while (!(sel ? ov2 : ov1) && t_lat < 200) begin
      @(posedge clk); #1;
      t_lat++;
    end
    repeat (hold) begin @(posedge clk); #1; end
    t_got = sel ? ov2 : ov1;
    t_res = sel ? {16'h0, res2} : res1;
    t_tg  = sel ? tg2 : tg1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
    int          lat;
  } vec_t;

  vec_t tv[17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [4:0]  t;
    int          l;
    bit          g;
    int          seen;
    logic [2:0]  o;
    logic [15:0] x, y, q16, r16, mag, pa, pb, ma, mb, ev;
    bit          s, isrem, mv, ms;
    int          ia, ib, lz, el, fl;

    // Directed 32-bit, 1 bit/cycle vectors: {op, a, b, expected, latency}
    tv[0]  = '{3'd5, 32'd100,        32'd7,          32'd14,         10};
    tv[1]  = '{3'd7, 32'd100,        32'd7,          32'd2,          2};
    tv[2]  = '{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   6};
    tv[3]  = '{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   2};
    tv[4]  = '{3'd6, 32'd7,          32'hFFFFFFFE,   32'd1,          6};
    tv[5]  = '{3'd4, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   2};
    tv[6]  = '{3'd4, 32'h55,         32'd0,          32'hFFFFFFFF,   3};
    tv[7]  = '{3'd7, 32'h1234,       32'd0,          32'h1234,       3};
    tv[8]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   35};
    tv[9]  = '{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'd0,          2};
    tv[10] = '{3'd5, 32'd0,          32'd5,          32'd0,          3};
    tv[11] = '{3'd7, 32'd0,          32'd5,          32'd0,          2};
    tv[12] = '{3'd5, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   35};
    tv[13] = '{3'd7, 32'hFFFFFFFF,   32'h10,         32'hF,          35};
    tv[14] = '{3'd0, 32'd100,        32'd7,          32'd14,         10};
    tv[15] = '{3'd4, 32'h80000000,   32'd2,          32'hC0000000,   35};
    tv[16] = '{3'd6, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   10};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    op = '0; a = '0; b = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, ov1}, 32'd0);
    chk("rst_result", res1, 32'd0);
    chk("rst_tag", {27'b0, tg1}, 32'd0);
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, ir1}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      issue(1'b0, tv[i].op, tv[i].a, tv[i].b, 5'(i + 3), -1, 0, r, t, l, g);
      chk($sformatf("v%0d_result", i), r, tv[i].expv);
      chk($sformatf("v%0d_tag", i), {27'b0, t}, {27'b0, 5'(i + 3)});
      chk($sformatf("v%0d_latency", i), 32'(l), 32'(tv[i].lat));
    end

    // Output stall: result and handshake held while out_ready stays low
    op = 3'd5; a = 32'd1000; b = 32'd10; tag = 5'd9; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; l = 1;
    while (!ov1 && l < 200) begin @(posedge clk); #1; l++; end
    chk("stall_latency", 32'(l), 32'd13);
    for (int k = 0; k < 10; k++) begin
      chk("stall_out_valid", {31'b0, ov1}, 32'd1);
      chk("stall_result", res1, 32'd100);
      chk("stall_in_ready", {31'b0, ir1}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release_valid", {31'b0, ov1}, 32'd0);
    chk("stall_release_ready", {31'b0, ir1}, 32'd1);

    // Flush mid-iteration: nothing delivered, cache not written
    issue(1'b0, 3'd5, 32'hFFFFFFFF, 32'd3, 5'd1, 5, 0, r, t, l, g);
    chk("flush_busy", {31'b0, busy1}, 32'd0);
    chk("flush_in_ready", {31'b0, ir1}, 32'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov1) seen = 1; end
    chk("flush_no_output", 32'(seen), 32'd0);
    issue(1'b0, 3'd5, 32'hFFFFFFFF, 32'd3, 5'd2, -1, 0, r, t, l, g);
    chk("post_flush_result", r, 32'h55555555);
    chk("post_flush_latency", 32'(l), 32'd35);

    // Flush together with a request in IDLE: request dropped
    op = 3'd5; a = 32'd9; b = 32'd3; iv1 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {31'b0, busy1}, 32'd0);
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (ov1) seen = 1; end
    chk("flush_idle_no_output", 32'(seen), 32'd0);

    // Asynchronous reset mid-operation, then prove the cache was invalidated
    op = 3'd5; a = 32'h0000FFFF; b = 32'd5; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", {31'b0, busy1}, 32'd0);
    chk("areset_in_ready", {31'b0, ir1}, 32'd1);
    chk("areset_out_valid", {31'b0, ov1}, 32'd0);
    chk("areset_result", res1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b0, 3'd7, 32'hFFFFFFFF, 32'd3, 5'd4, -1, 0, r, t, l, g);
    chk("areset_cache_result", r, 32'd0);
    chk("areset_cache_latency", 32'(l), 32'd35);

    // 16-bit, 2 bits/cycle sweep against a behavioural model
    mv = 1'b0; ma = '0; mb = '0; ms = 1'b0; pa = 16'd1; pb = 16'd1;
    for (int i = 0; i < 1500; i++) begin
      o = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      if ($urandom_range(0, 3) == 0) begin
        x = pa; y = pb;
      end else begin
        x = 16'($urandom) >> $urandom_range(0, 16);
        if ($urandom_range(0, 15) == 0) x = 16'h8000;
        y = ($urandom_range(0, 11) == 0) ? 16'd0 : 16'($urandom) >> $urandom_range(0, 15);
        if ($urandom_range(0, 15) == 0) y = 16'hFFFF;
      end
      s     = (o == 3'd4) || (o == 3'd6);
      isrem = (o == 3'd6) || (o == 3'd7);
      if (y == 16'd0) begin
        q16 = 16'hFFFF; r16 = x;
      end else if (s) begin
        ia = int'($signed(x)); ib = int'($signed(y));
        if (x == 16'h8000 && y == 16'hFFFF) begin
          q16 = 16'h8000; r16 = 16'd0;
        end else begin
          q16 = 16'(ia / ib); r16 = 16'(ia % ib);
        end
      end else begin
        q16 = x / y; r16 = x % y;
      end
      ev  = isrem ? r16 : q16;
      mag = (s && x[15]) ? -x : x;
      lz  = 16;
      for (int k = 0; k < 16; k++) if (mag[k]) lz = 15 - k;
      if (y == 16'd0)                               el = 3;
      else if (mv && ma == x && mb == y && ms == s) el = 2;
      else                                          el = 3 + (16 - lz + 1) / 2;
      fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, el - 2)) : -1;
      issue(1'b1, o, {16'h0, x}, {16'h0, y}, 5'(i), fl, int'($urandom_range(0, 2)), r, t, l, g);
      if (fl >= 0) begin
        chk($sformatf("sw%0d_flush_busy", i), {31'b0, busy2}, 32'd0);
        chk($sformatf("sw%0d_flush_valid", i), {31'b0, ov2}, 32'd0);
      end else begin
        chk($sformatf("sw%0d_result op=%0d a=%h b=%h", i, o, x, y), r, {16'h0, ev});
        chk($sformatf("sw%0d_tag", i), {27'b0, t}, {27'b0, 5'(i)});
        chk($sformatf("sw%0d_latency a=%h b=%h", i, x, y), 32'(l), 32'(el));
        if (y != 16'd0) begin
          mv = 1'b1; ma = x; mb = y; ms = s;
        end
      end
      pa = x; pb = y;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
